// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: opcodes, FSM states,
// instruction classes and the datapath mux-select codes driven per class.
package multicycle_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

  localparam logic [1:0] PC_SRC_PC4  = 2'd0;
  localparam logic [1:0] PC_SRC_ALU  = 2'd1;
  localparam logic [1:0] PC_SRC_JALR = 2'd2;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;

  localparam logic ALU_B_RS2 = 1'b0;
  localparam logic ALU_B_IMM = 1'b1;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_LUI,
    CLS_AUIPC,
    CLS_JAL,
    CLS_JALR,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_OPIMM,
    CLS_OP,
    CLS_ILLEGAL
  } op_class_e;

  // Selects that stay constant for the whole life of one instruction.
  typedef struct packed {
    logic [2:0] imm_sel;
    logic [1:0] alu_a_sel;
    logic       alu_b_sel;
    logic [1:0] wb_sel;
    logic [1:0] pc_src;
  } dp_sel_t;

  function automatic op_class_e classify(input logic [6:0] opcode);
    op_class_e cls;
    case (opcode)
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_OPIMM:  cls = CLS_OPIMM;
      OPC_OP:     cls = CLS_OP;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  function automatic dp_sel_t decode_sel(input op_class_e cls);
    dp_sel_t s;
    s.imm_sel   = IMM_I;
    s.alu_a_sel = ALU_A_RS1;
    s.alu_b_sel = ALU_B_IMM;
    s.wb_sel    = WB_ALU;
    s.pc_src    = PC_SRC_PC4;
    case (cls)
      CLS_OP:     s.alu_b_sel = ALU_B_RS2;
      CLS_LOAD:   s.wb_sel    = WB_MEM;
      CLS_STORE:  s.imm_sel   = IMM_S;
      CLS_BRANCH: begin
        s.imm_sel   = IMM_B;
        s.alu_a_sel = ALU_A_PC;
      end
      CLS_JAL: begin
        s.imm_sel   = IMM_J;
        s.alu_a_sel = ALU_A_PC;
        s.wb_sel    = WB_PC4;
        s.pc_src    = PC_SRC_ALU;
      end
      CLS_JALR: begin
        s.wb_sel = WB_PC4;
        s.pc_src = PC_SRC_JALR;
      end
      CLS_LUI: begin
        s.imm_sel   = IMM_U;
        s.alu_a_sel = ALU_A_ZERO;
      end
      CLS_AUIPC: begin
        s.imm_sel   = IMM_U;
        s.alu_a_sel = ALU_A_PC;
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags expiry when
// the TIMEOUT-th such cycle arrives; a ready in that same cycle suppresses it.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic ready_i,
  output logic expire_o
);

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expire_o = active_i && !ready_i && (count_q == CW'(TIMEOUT - 1));

  always_comb begin
    count_d = '0;
    if (active_i && !ready_i && !expire_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I core: drives the
// datapath selects and strobes, traps on illegal opcodes or memory timeouts.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  input  logic        br_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_inst,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [2:0]  imm_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        illegal,
  output logic        bus_err,
  output logic [31:0] instret
);

  state_e      state_q;
  logic        illegal_q;
  logic        bus_err_q;
  logic [31:0] instret_q;
  op_class_e   op_class;
  dp_sel_t     sel;
  logic        waiting;
  logic        timeout;
  logic        unused_inst_bits;

  assign unused_inst_bits = ^inst[31:7];
  assign op_class = classify(inst[6:0]);
  assign sel      = decode_sel(op_class);
  assign waiting  = (state_q == ST_FETCH) || (state_q == ST_MEM);

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign instret = instret_q;

  mem_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_mem_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .active_i (waiting),
    .ready_i  (mem_ready),
    .expire_o (timeout)
  );

  always_comb begin
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_is_inst = 1'b0;
    ir_we       = 1'b0;
    pc_we       = 1'b0;
    reg_we      = 1'b0;
    pc_src      = PC_SRC_PC4;
    imm_sel     = sel.imm_sel;
    alu_a_sel   = sel.alu_a_sel;
    alu_b_sel   = sel.alu_b_sel;
    wb_sel      = sel.wb_sel;
    case (state_q)
      ST_FETCH: begin
        mem_req     = 1'b1;
        mem_is_inst = 1'b1;
        ir_we       = mem_ready;
      end
      ST_EXEC: begin
        if (op_class == CLS_BRANCH) begin
          pc_we  = 1'b1;
          pc_src = br_taken ? PC_SRC_ALU : PC_SRC_PC4;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_we  = (op_class == CLS_STORE);
        pc_we   = (op_class == CLS_STORE) && mem_ready;
      end
      ST_WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
        pc_src = sel.pc_src;
      end
      default: ;
    endcase
    // Strobes must never fire during reset, whatever the stale state says.
    if (rst) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
      ir_we   = 1'b0;
      pc_we   = 1'b0;
      reg_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      if (pc_we) begin
        instret_q <= instret_q + 32'd1;
      end
      case (state_q)
        ST_FETCH: begin
          if (mem_ready) begin
            state_q <= ST_DECODE;
          end else if (timeout) begin
            state_q   <= ST_TRAP;
            bus_err_q <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (op_class == CLS_ILLEGAL) begin
            state_q   <= ST_TRAP;
            illegal_q <= 1'b1;
          end else begin
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_class)
            CLS_BRANCH:          state_q <= ST_FETCH;
            CLS_LOAD, CLS_STORE: state_q <= ST_MEM;
            default:             state_q <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (mem_ready) begin
            state_q <= (op_class == CLS_LOAD) ? ST_WB : ST_FETCH;
          end else if (timeout) begin
            state_q   <= ST_TRAP;
            bus_err_q <= 1'b1;
          end
        end
        ST_WB:   state_q <= ST_FETCH;
        default: state_q <= ST_TRAP;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed RV32I instructions plus a randomized
// instruction stream, checked cycle by cycle against a per-class phase model.
module tb_multicycle_ctrl;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst;
  logic        mem_ready;
  logic        br_taken;
  logic        mem_req, mem_we, mem_is_inst, ir_we, pc_we, reg_we;
  logic [1:0]  pc_src, alu_a_sel, wb_sel;
  logic [2:0]  imm_sel;
  logic        alu_b_sel;
  logic        illegal, bus_err;
  logic [31:0] instret;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_instret = 32'd0;
  logic [6:0]  ops [9];

  typedef struct packed {
    logic       illegal;
    logic       bus_err;
    logic       mem_req;
    logic       mem_we;
    logic       mem_is_inst;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic [1:0] pc_src;
    logic [2:0] imm_sel;
    logic [1:0] alu_a;
    logic       alu_b;
    logic [1:0] wb;
  } obs_t;

  // Per-class behaviour as listed in the instruction table.
  typedef struct packed {
    logic       legal;
    logic [2:0] imm;
    logic [1:0] a;
    logic       b;
    logic [1:0] wb;
    logic [1:0] jsrc;
    logic       mem;
    logic       store;
    logic       branch;
  } info_t;

  multicycle_ctrl #(.TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .inst        (inst),
    .mem_ready   (mem_ready),
    .br_taken    (br_taken),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_is_inst (mem_is_inst),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .pc_src      (pc_src),
    .imm_sel     (imm_sel),
    .alu_a_sel   (alu_a_sel),
    .alu_b_sel   (alu_b_sel),
    .reg_we      (reg_we),
    .wb_sel      (wb_sel),
    .illegal     (illegal),
    .bus_err     (bus_err),
    .instret     (instret)
  );

  always #5 clk = ~clk;

  function automatic info_t spec_info(input logic [6:0] opc);
    info_t r;
    r = '0;
    r.legal = 1'b1;
    r.b = 1'b1;
    case (opc)
      7'b0010011: ;
      7'b0110011: r.b = 1'b0;
      7'b0000011: begin r.mem = 1'b1; r.wb = 2'd1; end
      7'b0100011: begin r.imm = 3'd1; r.mem = 1'b1; r.store = 1'b1; end
      7'b1100011: begin r.imm = 3'd2; r.a = 2'd1; r.branch = 1'b1; end
      7'b1101111: begin r.imm = 3'd3; r.a = 2'd1; r.wb = 2'd2; r.jsrc = 2'd1; end
      7'b1100111: begin r.wb = 2'd2; r.jsrc = 2'd2; end
      7'b0110111: begin r.imm = 3'd4; r.a = 2'd2; end
      7'b0010111: begin r.imm = 3'd4; r.a = 2'd1; end
      default:    r.legal = 1'b0;
    endcase
    return r;
  endfunction

  function automatic obs_t strobe_mask();
    obs_t m;
    m = '0;
    m.illegal = 1'b1;
    m.bus_err = 1'b1;
    m.mem_req = 1'b1;
    m.mem_we  = 1'b1;
    m.ir_we   = 1'b1;
    m.pc_we   = 1'b1;
    m.reg_we  = 1'b1;
    return m;
  endfunction

  task automatic check_cycle(input string tag, input obs_t e, input obs_t m);
    logic [17:0] gv, ev, mv;
    @(negedge clk);
    gv = {illegal, bus_err, mem_req, mem_we, mem_is_inst, ir_we, pc_we, reg_we,
          pc_src, imm_sel, alu_a_sel, alu_b_sel, wb_sel};
    ev = e;
    mv = m;
    vectors++;
    assert ((gv & mv) === (ev & mv)) else begin
      miscompares++;
      $error("FAIL %s: observed %h required %h (mask %h)", tag, gv & mv, ev & mv, mv);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag, input logic exp_ill, input logic exp_berr);
    vectors++;
    assert ({illegal, bus_err, instret} === {exp_ill, exp_berr, exp_instret}) else begin
      miscompares++;
      $error("FAIL %s: observed ill=%0b berr=%0b instret=%0d required ill=%0b berr=%0b instret=%0d",
             tag, illegal, bus_err, instret, exp_ill, exp_berr, exp_instret);
    end
  endtask

  task automatic apply_reset(input int n);
    obs_t e, m;
    rst = 1'b1;
    mem_ready = 1'b1;
    br_taken = 1'b1;
    for (int i = 0; i < n; i++) begin
      e = '0;
      m = strobe_mask();
      if (i == 0) begin
        m.illegal = 1'b0;
        m.bus_err = 1'b0;
      end
      check_cycle("reset_strobes", e, m);
    end
    exp_instret = 32'd0;
    check_counters("reset_state", 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] ins, input int fwait, input int mwait, input logic br);
    info_t inf;
    obs_t  e, m, sel_e, sel_m;
    inf = spec_info(ins[6:0]);
    inst = ins;
    br_taken = br;
    for (int i = 0; i <= fwait; i++) begin
      mem_ready = (i == fwait);
      e = '0;
      e.mem_req = 1'b1;
      e.mem_is_inst = 1'b1;
      e.ir_we = mem_ready;
      m = strobe_mask();
      m.mem_is_inst = 1'b1;
      check_cycle($sformatf("fetch %h", ins), e, m);
    end
    sel_e = '0;
    sel_e.imm_sel = inf.imm;
    sel_e.alu_a = inf.a;
    sel_e.alu_b = inf.b;
    sel_m = strobe_mask();
    sel_m.imm_sel = '1;
    sel_m.alu_a = '1;
    sel_m.alu_b = 1'b1;
    mem_ready = 1'($urandom_range(0, 1));
    check_cycle($sformatf("decode %h", ins), sel_e, sel_m);
    e = sel_e;
    m = sel_m;
    if (inf.branch) begin
      e.pc_we = 1'b1;
      e.pc_src = br ? 2'd1 : 2'd0;
      m.pc_src = '1;
    end
    check_cycle($sformatf("exec %h", ins), e, m);
    if (inf.mem) begin
      for (int i = 0; i <= mwait; i++) begin
        mem_ready = (i == mwait);
        e = sel_e;
        m = sel_m;
        e.mem_req = 1'b1;
        e.mem_we = inf.store;
        m.mem_is_inst = 1'b1;
        if (inf.store && mem_ready) begin
          e.pc_we = 1'b1;
          m.pc_src = '1;
        end
        check_cycle($sformatf("mem %h", ins), e, m);
      end
    end
    if (!inf.branch && !inf.store) begin
      e = sel_e;
      m = sel_m;
      e.reg_we = 1'b1;
      e.pc_we = 1'b1;
      e.pc_src = inf.jsrc;
      e.wb = inf.wb;
      m.pc_src = '1;
      m.wb = '1;
      check_cycle($sformatf("wb %h", ins), e, m);
    end
    exp_instret = exp_instret + 32'd1;
    check_counters($sformatf("retire %h", ins), 1'b0, 1'b0);
    $display("instr %h fwait=%0d mwait=%0d br=%0b instret=%0d", ins, fwait, mwait, br, instret);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    obs_t e, m;
    logic [31:0] ins;
    int k;
    ops = '{7'h13, 7'h33, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
    inst = 32'h00500093;
    apply_reset(3);

    run_instr(32'h00500093, 0, 0, 1'b0);   // ADDI x1,x0,5
    run_instr(32'h0000A103, 0, 3, 1'b0);   // LW, ready on the timeout boundary
    run_instr(32'h0020A023, 0, 0, 1'b0);   // SW
    run_instr(32'h00208463, 0, 0, 1'b1);   // BEQ taken
    run_instr(32'h00208463, 0, 0, 1'b0);   // BEQ not taken
    run_instr(32'h000080E7, 1, 0, 1'b0);   // JALR
    run_instr(32'h123450B7, 3, 0, 1'b0);   // LUI, fetch ready on boundary

    for (int n = 0; n < 60; n++) begin
      k = $urandom_range(0, 8);
      ins = $urandom();
      ins[6:0] = ops[k];
      run_instr(ins, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Illegal opcode: trap after decode, strobes stay low.
    inst = 32'h0000007F;
    mem_ready = 1'b1;
    e = '0;
    e.mem_req = 1'b1;
    e.mem_is_inst = 1'b1;
    e.ir_we = 1'b1;
    m = strobe_mask();
    m.mem_is_inst = 1'b1;
    check_cycle("illegal_fetch", e, m);
    check_cycle("illegal_decode", '0, strobe_mask());
    for (int i = 0; i < 20; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      br_taken = 1'($urandom_range(0, 1));
      e = '0;
      e.illegal = 1'b1;
      check_cycle("illegal_trap", e, strobe_mask());
    end
    check_counters("illegal_instret", 1'b1, 1'b0);
    apply_reset(2);

    // Fetch timeout: TMO not-ready cycles, then bus error trap.
    inst = 32'h00500093;
    mem_ready = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      e = '0;
      e.mem_req = 1'b1;
      check_cycle("tmo_fetch_wait", e, strobe_mask());
    end
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      e = '0;
      e.bus_err = 1'b1;
      check_cycle("tmo_fetch_trap", e, strobe_mask());
    end
    apply_reset(1);

    // Data-access timeout during a load.
    inst = 32'h0000A103;
    mem_ready = 1'b1;
    e = '0;
    e.mem_req = 1'b1;
    e.ir_we = 1'b1;
    check_cycle("tmo_mem_fetch", e, strobe_mask());
    check_cycle("tmo_mem_decode", '0, strobe_mask());
    check_cycle("tmo_mem_exec", '0, strobe_mask());
    mem_ready = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      e = '0;
      e.mem_req = 1'b1;
      check_cycle("tmo_mem_wait", e, strobe_mask());
    end
    e = '0;
    e.bus_err = 1'b1;
    check_cycle("tmo_mem_trap", e, strobe_mask());
    apply_reset(1);

    // Reset in the middle of a fetch wait drops the request.
    run_instr(32'h00500093, 0, 0, 1'b0);
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = '0;
      e.mem_req = 1'b1;
      check_cycle("midrst_wait", e, strobe_mask());
    end
    apply_reset(1);
    run_instr(32'h00500093, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
